i2c_reg_sequencer: RTL and testbench
====================================

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 Parameter PRESCALE, default 16'd199, is the I2C core prescaler (100 MHz clock, 100 kHz SCL).
REQ-002 wb_clk_i  in  1  sole clock.
REQ-003 wb_rst_ni  in  1  reset; asynchronous, active-low.
REQ-004 req_valid_i  in  1  request valid.
REQ-005 req_ready_o  out  1  request accepted when valid&&ready.
REQ-006 req_rnw_i  in  1  1=register read, 0=register write.
REQ-007 req_dev_i  in  7  I2C 7-bit device address.
REQ-008 req_reg_i  in  8  device register address.
REQ-009 req_wdata_i  in  8  write data.
REQ-010 rsp_valid_o  out  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_rdata_o  out  8  read data; 8'h00 for writes.
REQ-012 rsp_nack_o  out  1  device NACKed; valid with rsp_valid_o.
REQ-013 init_done_o  out  1  core configured.
REQ-014 m_wb_adr_o[3], m_wb_dat_o[8], m_wb_we_o, m_wb_stb_o, m_wb_cyc_o  out; m_wb_dat_i[8], m_wb_ack_i  in; Wishbone master to the blocking I2C wrapper.

Function
REQ-015 Wishbone access: cyc_o and stb_o rise together with adr/dat/we stable; held until ack_i; both low the cycle after ack_i; at least one idle cycle between accesses.
REQ-016 Ack arrives only after the I2C byte transfer completes (TIP clear); no busy polling in this block.
REQ-017 Register map: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR(w)/RXR(r), 4 CR(w)/SR(r); SR bit7 = RxACK (1=NACK).
REQ-018 After reset: INIT writes PRESCALE[7:0]->0, PRESCALE[15:8]->1, 8'h80->2; then init_done_o=1, state IDLE.
REQ-019 req_ready_o=1 only in IDLE with init_done_o=1; request fields latched on accept.
REQ-020 Write sequence: TXR={dev,0}; CR=8'h90; read SR; TXR=reg; CR=8'h10; read SR; TXR=wdata; CR=8'h50; read SR.
REQ-021 Read sequence: TXR={dev,0}; CR=8'h90; SR; TXR=reg; CR=8'h10; SR; TXR={dev,1}; CR=8'h90; SR; CR=8'h68; read RXR.
REQ-022 Any SR read with bit7=1: abort remaining steps, write CR=8'h40 (STOP), then respond rsp_nack_o=1, rsp_rdata_o=0.
REQ-023 Final SR after wdata write with bit7=1 (NACK with STO already issued): respond nack without extra STOP.
REQ-024 Completion: rsp_valid_o pulses one cycle on return to IDLE; req_ready_o rises the cycle after the pulse.
REQ-025 States: RESET_INIT, IDLE, STEP (step counter 0..10 indexing REQ-020/021 tables), ABORT_STOP, RESPOND.
REQ-026 rsp_rdata_o/rsp_nack_o hold value until next rsp_valid_o.

Reset
REQ-027 Asserting wb_rst_ni low at any time (incl. mid-access) immediately forces cyc/stb/we=0, adr/dat=0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_nack_o=0, init_done_o=0, state RESET_INIT, step=0.
REQ-028 After release, INIT reruns fully; an in-flight request is dropped with no response.

Structure
REQ-029 Package i2c_seq_pkg: register address constants, CR command constants (STA_WR 8'h90, WR 8'h10, STO_WR 8'h50, RD_NACK_STO 8'h68, STO 8'h40), state enum.
REQ-030 Sub-module i2c_wb_access: single-access Wishbone engine (start/adr/dat/we in, done/rdata out) implementing REQ-015.

Verification
REQ-031 Reset release, wrapper model acks after 3 cycles -> exactly writes 0:C7, 1:00, 2:80, then init_done_o=1.
REQ-032 Write dev 7'h50 reg 8'h12 data 8'hA5, all ACK -> TXR 8'hA0, CR 90, TXR 12, CR 10, TXR A5, CR 50; rsp_nack_o=0.
REQ-033 Read dev 7'h50 reg 8'h34, RXR returns 8'h5C -> TXR A0/34/A1 sequence, CR 68, rsp_rdata_o=8'h5C, rsp_nack_o=0.
REQ-034 Address NACK (first SR=8'h80) -> CR=8'h40 written next, rsp_nack_o=1, no further TXR writes.
REQ-035 Reset asserted while stb_o high awaiting ack -> outputs zero same cycle; after release INIT reruns, no rsp_valid_o.
REQ-036 req_valid_i held high continuously -> back-to-back requests, ready low between accept and pulse, one response per request.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C register sequencer.
// Holds the I2C core register map, command-register byte values,
// the sequencer state encoding, and the table of bus accesses that
// make up a register write or a register read.
package i2c_seq_pkg;

  // I2C core register map. TXR/RXR and CR/SR share an address;
  // the direction of the access selects which register is used.
  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXR    = 3'd3;
  localparam logic [2:0] REG_RXR    = 3'd3;
  localparam logic [2:0] REG_CR     = 3'd4;
  localparam logic [2:0] REG_SR     = 3'd4;

  // Byte values written to the core.
  localparam logic [7:0] CTR_EN         = 8'h80;
  localparam logic [7:0] CR_STA_WR      = 8'h90;
  localparam logic [7:0] CR_WR          = 8'h10;
  localparam logic [7:0] CR_STO_WR      = 8'h50;
  localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CR_STO         = 8'h40;

  // SR bit that reports the slave acknowledge (1 = NACK).
  localparam int SR_RXACK_BIT = 7;

  typedef enum logic [2:0] {
    ST_RESET_INIT,
    ST_IDLE,
    ST_STEP,
    ST_ABORT_STOP,
    ST_RESPOND
  } state_e;

  // One bus access of a transaction: where, what, which direction,
  // whether it is a status read to test for NACK, and whether it ends
  // the transaction.
  typedef struct packed {
    logic [2:0] adr;
    logic [7:0] dat;
    logic       we;
    logic       sr;
    logic       last;
  } step_t;

  // Steps 0..5 are common (address phase then register-address phase).
  // Writes end at step 8 (data byte with STOP, then its status);
  // reads continue with a repeated START, a NACK+STOP read and the RXR fetch.
  function automatic step_t seq_step(input logic       rnw,
                                     input logic [3:0] step,
                                     input logic [6:0] dev,
                                     input logic [7:0] rg,
                                     input logic [7:0] wd);
    step_t s;
    s = '{adr: REG_TXR, dat: 8'h00, we: 1'b1, sr: 1'b0, last: 1'b0};
    case (step)
      4'd0: s.dat = {dev, 1'b0};
      4'd1: begin s.adr = REG_CR; s.dat = CR_STA_WR; end
      4'd2, 4'd5, 4'd8: begin
        s.adr  = REG_SR;
        s.we   = 1'b0;
        s.sr   = 1'b1;
        s.last = !rnw && (step == 4'd8);
      end
      4'd3: s.dat = rg;
      4'd4: begin s.adr = REG_CR; s.dat = CR_WR; end
      4'd6: s.dat = rnw ? {dev, 1'b1} : wd;
      4'd7: begin s.adr = REG_CR; s.dat = rnw ? CR_STA_WR : CR_STO_WR; end
      4'd9: begin s.adr = REG_CR; s.dat = CR_RD_NACK_STO; end
      default: begin s.adr = REG_RXR; s.we = 1'b0; s.last = 1'b1; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/i2c_wb_access.sv
// Single-access Wishbone master engine.
// Ports: start_i/adr_i/dat_i/we_i request one access (ignored while busy);
// busy_o is high while the access is on the bus; done_o pulses in the
// cycle ack is seen, with rdata_o carrying the returned byte in that cycle.
// m_wb_* is the Wishbone master bus (cyc and stb always move together).
module i2c_wb_access (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  input  logic       we_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [2:0] m_wb_adr_o,
  output logic [7:0] m_wb_dat_o,
  output logic       m_wb_we_o,
  output logic       m_wb_stb_o,
  output logic       m_wb_cyc_o,
  input  logic [7:0] m_wb_dat_i,
  input  logic       m_wb_ack_i
);

  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 3'd0;
      dat_q <= 8'h00;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  // Address/data/we are captured together with cyc, so they are stable
  // for the whole access. cyc drops on the edge that samples ack, which
  // forces at least one idle cycle before the next start can take effect.
  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (m_wb_ack_i) cyc_d = 1'b0;
    end else if (start_i) begin
      cyc_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = dat_i;
    end
  end

  assign busy_o     = cyc_q;
  assign done_o     = cyc_q && m_wb_ack_i;
  assign rdata_o    = m_wb_dat_i;
  assign m_wb_cyc_o = cyc_q;
  assign m_wb_stb_o = cyc_q;
  assign m_wb_we_o  = we_q;
  assign m_wb_adr_o = adr_q;
  assign m_wb_dat_o = dat_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// I2C register read/write sequencer driving an I2C master core through a
// blocking Wishbone wrapper.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset;
// req_* request handshake (rnw, 7-bit device, register, write data);
// rsp_* one-cycle completion pulse with read data and NACK flag;
// init_done_o high once the core has been configured;
// m_wb_* Wishbone master to the I2C wrapper.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd199
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rnw_i,
  input  logic [6:0] req_dev_i,
  input  logic [7:0] req_reg_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_nack_o,
  output logic       init_done_o,
  output logic [2:0] m_wb_adr_o,
  output logic [7:0] m_wb_dat_o,
  output logic       m_wb_we_o,
  output logic       m_wb_stb_o,
  output logic       m_wb_cyc_o,
  input  logic [7:0] m_wb_dat_i,
  input  logic       m_wb_ack_i
);

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_nack_q, rsp_nack_d;

  logic       rnw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q;

  logic       accept;
  step_t      cur;
  logic       nack_seen;
  logic       acc_start, acc_we, acc_busy, acc_done;
  logic [2:0] acc_adr;
  logic [7:0] acc_dat, acc_rdata;

  assign cur       = seq_step(rnw_q, step_q, dev_q, reg_q, wdata_q);
  assign nack_seen = cur.sr && acc_rdata[SR_RXACK_BIT];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_RESET_INIT;
      step_q      <= 4'd0;
      rsp_rdata_q <= 8'h00;
      rsp_nack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
    end
  end

  // Request fields are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      rnw_q   <= req_rnw_i;
      dev_q   <= req_dev_i;
      reg_q   <= req_reg_i;
      wdata_q <= req_wdata_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_nack_d  = rsp_nack_q;
    case (state_q)
      ST_RESET_INIT: begin
        if (acc_done) begin
          if (step_q == 4'd2) begin
            state_d = ST_IDLE;
            step_d  = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_STEP;
          step_d  = 4'd0;
        end
      end
      ST_STEP: begin
        if (acc_done) begin
          if (nack_seen) begin
            // A NACK on the final write status already had STOP issued
            // with the data byte, so no separate STOP is needed.
            if (cur.last) begin
              state_d     = ST_RESPOND;
              rsp_rdata_d = 8'h00;
              rsp_nack_d  = 1'b1;
            end else begin
              state_d = ST_ABORT_STOP;
            end
          end else if (cur.last) begin
            state_d     = ST_RESPOND;
            rsp_rdata_d = rnw_q ? acc_rdata : 8'h00;
            rsp_nack_d  = 1'b0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      ST_ABORT_STOP: begin
        if (acc_done) begin
          state_d     = ST_RESPOND;
          rsp_rdata_d = 8'h00;
          rsp_nack_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
      end
    endcase
  end

  // Outputs and the access request for the current state. A new access is
  // requested only once the engine is idle, i.e. after the previous ack.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    accept      = (state_q == ST_IDLE) && req_valid_i;
    rsp_valid_o = (state_q == ST_RESPOND);
    init_done_o = (state_q != ST_RESET_INIT);
    acc_start   = 1'b0;
    acc_adr     = REG_PRERLO;
    acc_dat     = 8'h00;
    acc_we      = 1'b0;
    case (state_q)
      ST_RESET_INIT: begin
        acc_start = !acc_busy;
        acc_we    = 1'b1;
        case (step_q)
          4'd0:    begin acc_adr = REG_PRERLO; acc_dat = PRESCALE[7:0];  end
          4'd1:    begin acc_adr = REG_PRERHI; acc_dat = PRESCALE[15:8]; end
          default: begin acc_adr = REG_CTR;    acc_dat = CTR_EN;         end
        endcase
      end
      ST_STEP: begin
        acc_start = !acc_busy;
        acc_adr   = cur.adr;
        acc_dat   = cur.dat;
        acc_we    = cur.we;
      end
      ST_ABORT_STOP: begin
        acc_start = !acc_busy;
        acc_adr   = REG_CR;
        acc_dat   = CR_STO;
        acc_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_nack_o  = rsp_nack_q;

  i2c_wb_access u_wb_access (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .start_i    (acc_start),
    .adr_i      (acc_adr),
    .dat_i      (acc_dat),
    .we_i       (acc_we),
    .busy_o     (acc_busy),
    .done_o     (acc_done),
    .rdata_o    (acc_rdata),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_cyc_o (m_wb_cyc_o),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_ack_i (m_wb_ack_i)
  );

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a wrapper model that acks each
// access after three cycles, plus scoreboards of expected bus accesses and
// responses.
module tb_i2c_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid, rsp_nack, init_done;
  logic [7:0] rsp_rdata;
  logic [2:0] m_wb_adr;
  logic [7:0] m_wb_dat_o, m_wb_dat_i;
  logic       m_wb_we, m_wb_stb, m_wb_cyc, m_wb_ack;

  int tests = 0;
  int fails = 0;

  logic [11:0] exp_acc[$];
  logic [8:0]  exp_rsp[$];
  logic [7:0]  sr_q[$];
  logic [7:0]  rxr_val;
  logic [11:0] held_key, cur_key;
  int          cnt;
  int          rsp_count;
  logic        outstanding;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.PRESCALE(16'd199)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rnw_i   (req_rnw),
    .req_dev_i   (req_dev),
    .req_reg_i   (req_reg),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_nack_o  (rsp_nack),
    .init_done_o (init_done),
    .m_wb_adr_o  (m_wb_adr),
    .m_wb_dat_o  (m_wb_dat_o),
    .m_wb_we_o   (m_wb_we),
    .m_wb_stb_o  (m_wb_stb),
    .m_wb_cyc_o  (m_wb_cyc),
    .m_wb_dat_i  (m_wb_dat_i),
    .m_wb_ack_i  (m_wb_ack)
  );

  function automatic logic [11:0] acc_key(input logic we, input logic [2:0] adr,
                                          input logic [7:0] dat);
    return {we, adr, we ? dat : 8'h00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wrapper model, scoreboards and handshake monitor, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_wb_ack    = 1'b0;
      cnt         = 0;
      outstanding = 1'b0;
    end else begin
      if (m_wb_ack) begin
        m_wb_ack = 1'b0;
        check("stb_drop_after_ack", {30'd0, m_wb_cyc, m_wb_stb}, 32'd0);
      end else if (m_wb_cyc || m_wb_stb) begin
        check("cyc_eq_stb", {31'd0, m_wb_cyc}, {31'd0, m_wb_stb});
        cur_key = {m_wb_we, m_wb_adr, m_wb_dat_o};
        if (cnt == 0) held_key = cur_key;
        else check("wb_stable", {20'd0, cur_key}, {20'd0, held_key});
        cnt++;
        if (cnt == 3) begin
          cnt      = 0;
          m_wb_ack = 1'b1;
          if (m_wb_we) m_wb_dat_i = 8'hFF;
          else if (m_wb_adr == 3'd4) m_wb_dat_i = (sr_q.size() > 0) ? sr_q.pop_front() : 8'h00;
          else m_wb_dat_i = rxr_val;
          if (exp_acc.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL acc_extra: got %h expected no access", cur_key);
          end else begin
            check("acc", {20'd0, acc_key(m_wb_we, m_wb_adr, m_wb_dat_o)},
                  {20'd0, exp_acc.pop_front()});
          end
        end
      end
      if (rsp_valid) begin
        rsp_count++;
        if (exp_rsp.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL rsp_extra: got %h expected no response", {rsp_rdata, rsp_nack});
        end else begin
          check("rsp", {23'd0, rsp_rdata, rsp_nack}, {23'd0, exp_rsp.pop_front()});
        end
      end
      if (outstanding) begin
        check("ready_low_busy", {31'd0, req_ready}, 32'd0);
        if (rsp_valid) outstanding = 1'b0;
      end else if (req_valid && req_ready) begin
        outstanding = 1'b1;
      end
    end
  end

  task automatic push_init();
    exp_acc.push_back(acc_key(1'b1, 3'd0, 8'hC7));
    exp_acc.push_back(acc_key(1'b1, 3'd1, 8'h00));
    exp_acc.push_back(acc_key(1'b1, 3'd2, 8'h80));
  endtask

  task automatic push_head(input logic [6:0] dev, input logic [7:0] rg);
    exp_acc.push_back(acc_key(1'b1, 3'd3, {dev, 1'b0}));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h90));
    exp_acc.push_back(acc_key(1'b0, 3'd4, 8'h00));
    exp_acc.push_back(acc_key(1'b1, 3'd3, rg));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h10));
    exp_acc.push_back(acc_key(1'b0, 3'd4, 8'h00));
  endtask

  task automatic push_write(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    push_head(dev, rg);
    exp_acc.push_back(acc_key(1'b1, 3'd3, wd));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h50));
    exp_acc.push_back(acc_key(1'b0, 3'd4, 8'h00));
  endtask

  task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
    int i;
    @(posedge clk);
    #1;
    req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
    req_valid = 1'b1;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check("req_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 500 && !init_done; i++) @(negedge clk);
    check("init_done", {31'd0, init_done}, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && (exp_acc.size() != 0 || exp_rsp.size() != 0); i++)
      @(negedge clk);
    check(tag, exp_acc.size() + exp_rsp.size(), 32'd0);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_cyc_stb_we"}, {29'd0, m_wb_cyc, m_wb_stb, m_wb_we}, 32'd0);
    check({pfx, "_adr_dat"}, {21'd0, m_wb_adr, m_wb_dat_o}, 32'd0);
    check({pfx, "_ready"}, {31'd0, req_ready}, 32'd0);
    check({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({pfx, "_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    check({pfx, "_nack"}, {31'd0, rsp_nack}, 32'd0);
    check({pfx, "_init_done"}, {31'd0, init_done}, 32'd0);
  endtask

  initial begin
    int n;
    int rc;
    rst_n = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_dev = 7'd0;
    req_reg = 8'h00; req_wdata = 8'h00; m_wb_ack = 1'b0; m_wb_dat_i = 8'h00;
    rxr_val = 8'h00; rsp_count = 0; outstanding = 1'b0; cnt = 0;
    held_key = 12'd0; cur_key = 12'd0;

    // Reset state and initialisation writes.
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("rst");
    push_init();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    drain("init_drain");
    @(negedge clk);
    check("ready_after_init", {31'd0, req_ready}, 32'd1);

    // Register write, all acknowledged.
    push_write(7'h50, 8'h12, 8'hA5);
    exp_rsp.push_back({8'h00, 1'b0});
    do_req(1'b0, 7'h50, 8'h12, 8'hA5);
    drain("wr_drain");

    // Register read returning 8'h5C.
    rxr_val = 8'h5C;
    push_head(7'h50, 8'h34);
    exp_acc.push_back(acc_key(1'b1, 3'd3, 8'hA1));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h90));
    exp_acc.push_back(acc_key(1'b0, 3'd4, 8'h00));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h68));
    exp_acc.push_back(acc_key(1'b0, 3'd3, 8'h00));
    exp_rsp.push_back({8'h5C, 1'b0});
    do_req(1'b1, 7'h50, 8'h34, 8'h00);
    drain("rd_drain");

    // Address NACK on the first status read: STOP, no further TXR writes.
    sr_q.push_back(8'h80);
    exp_acc.push_back(acc_key(1'b1, 3'd3, 8'hA0));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h90));
    exp_acc.push_back(acc_key(1'b0, 3'd4, 8'h00));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h40));
    exp_rsp.push_back({8'h00, 1'b1});
    do_req(1'b0, 7'h50, 8'h12, 8'hA5);
    drain("addr_nack_drain");

    // Read with NACK on the repeated-start address: STOP before RXR.
    rxr_val = 8'h3B;
    sr_q.push_back(8'h00); sr_q.push_back(8'h00); sr_q.push_back(8'h80);
    push_head(7'h2A, 8'h07);
    exp_acc.push_back(acc_key(1'b1, 3'd3, 8'h55));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h90));
    exp_acc.push_back(acc_key(1'b0, 3'd4, 8'h00));
    exp_acc.push_back(acc_key(1'b1, 3'd4, 8'h40));
    exp_rsp.push_back({8'h00, 1'b1});
    do_req(1'b1, 7'h2A, 8'h07, 8'h00);
    drain("rd_nack_drain");

    // NACK on the data byte of a write: STOP already issued, none added.
    sr_q.push_back(8'h00); sr_q.push_back(8'h00); sr_q.push_back(8'h80);
    push_write(7'h50, 8'h12, 8'h3C);
    exp_rsp.push_back({8'h00, 1'b1});
    do_req(1'b0, 7'h50, 8'h12, 8'h3C);
    drain("data_nack_drain");

    // Reset while an access waits for ack: in-flight request is dropped.
    do_req(1'b0, 7'h50, 8'h12, 8'hA5);
    for (int i = 0; i < 100 && !m_wb_stb; i++) @(negedge clk);
    check("stb_seen", {31'd0, m_wb_stb}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_acc.delete();
    exp_rsp.delete();
    sr_q.delete();
    #1 check_zero_outputs("midrst");
    rc = rsp_count;
    push_init();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    drain("reinit_drain");
    repeat (5) @(negedge clk);
    check("no_rsp_after_reset", rsp_count, rc);

    // Back-to-back requests with valid held high throughout.
    push_write(7'h50, 8'h12, 8'h11);
    push_write(7'h50, 8'h12, 8'h22);
    push_write(7'h50, 8'h12, 8'h33);
    repeat (3) exp_rsp.push_back({8'h00, 1'b0});
    @(posedge clk);
    #1;
    req_rnw = 1'b0; req_dev = 7'h50; req_reg = 8'h12; req_wdata = 8'h11;
    req_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && n < 3; i++) begin
      @(negedge clk);
      if (req_ready) begin
        n++;
        @(posedge clk);
        #1;
        if (n == 1) req_wdata = 8'h22;
        else if (n == 2) req_wdata = 8'h33;
        else req_valid = 1'b0;
      end
    end
    check("b2b_accepts", n, 32'd3);
    drain("b2b_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
